// File: rtl/uart_prog_loader.sv
// uart_prog_loader: 8N1 UART receiver that packs bytes MSB-first into words and streams them into instruction memory.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic                  rx_i,
  output logic                  ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  done_o,
  output logic                  frame_err_o,
  output logic                  ovf_o,
  output logic [ADDR_WIDTH:0]   word_count_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [31:0] MARKER = 32'h0000_0FFF;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE} ld_state_t;
  logic                  rx_meta_q, rx_q;
  rx_state_t             rs_q;
  logic [CW-1:0]         cnt_q;
  logic [2:0]            bit_q;
  logic [7:0]            byte_q;
  logic                  byte_valid_q, stop_err_q;
  ld_state_t             ls_q;
  logic [1:0]            idx_q;
  logic [23:0]           word_q;
  logic [31:0]           word_d;
  logic                  we_q, done_q, ferr_q, ovf_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [ADDR_WIDTH:0]   wc_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) {rx_meta_q, rx_q} <= 2'b11;
    else {rx_meta_q, rx_q} <= {rx_i, rx_meta_q};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rs_q         <= R_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      stop_err_q   <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      stop_err_q   <= 1'b0;
      case (rs_q)
        R_IDLE: begin
          cnt_q <= '0;
          if (!rx_q) rs_q <= R_START;
        end
        R_START:
          if (cnt_q == HALF) begin
            cnt_q <= '0;
            bit_q <= '0;
            rs_q  <= rx_q ? R_IDLE : R_DATA;
          end else cnt_q <= cnt_q + 1'b1;
        R_DATA:
          if (cnt_q == FULL) begin
            cnt_q  <= '0;
            byte_q <= {rx_q, byte_q[7:1]};
            bit_q  <= bit_q + 1'b1;
            if (bit_q == 3'd7) rs_q <= R_STOP;
          end else cnt_q <= cnt_q + 1'b1;
        R_STOP:
          if (cnt_q == FULL) begin
            cnt_q        <= '0;
            byte_valid_q <= rx_q;
            stop_err_q   <= !rx_q;
            rs_q         <= R_IDLE;
          end else cnt_q <= cnt_q + 1'b1;
      endcase
    end
  always_comb word_d = {word_q, byte_q};
  // Abort on enable fall takes priority over a byte completing in the same cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ls_q    <= L_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wc_q    <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (stop_err_q) ferr_q <= 1'b1;
      case (ls_q)
        L_IDLE:
          if (enable_i) begin
            ls_q   <= L_LOAD;
            idx_q  <= '0;
            word_q <= '0;
            wc_q   <= '0;
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
          end
        L_LOAD:
          if (!enable_i) ls_q <= L_IDLE;
          else if (byte_valid_q) begin
            word_q <= word_d[23:0];
            idx_q  <= idx_q + 1'b1;
            if (idx_q == 2'd3) begin
              if (word_d == MARKER) begin
                done_q <= 1'b1;
                ls_q   <= L_DONE;
              end else begin
                we_q    <= 1'b1;
                addr_q  <= wc_q[ADDR_WIDTH-1:0];
                wdata_q <= word_d;
                wc_q    <= wc_q + 1'b1;
                if (&wc_q[ADDR_WIDTH-1:0]) begin
                  done_q <= 1'b1;
                  ovf_q  <= 1'b1;
                  ls_q   <= L_DONE;
                end
              end
            end
          end
        L_DONE: if (!enable_i) ls_q <= L_IDLE;
        default: ls_q <= L_IDLE;
      endcase
    end
  assign ready_o      = ls_q == L_LOAD;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign done_o       = done_q;
  assign frame_err_o  = ferr_q;
  assign ovf_o        = ovf_q;
  assign word_count_o = wc_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed UART downloads with a write scoreboard checked by an independent monitor.
module tb_uart_prog_loader;
  localparam int CPB = 16;
  localparam int AW  = 2;
  logic          clk = 1'b0, rst = 1'b1, enable_i = 1'b0, rx_i = 1'b1;
  logic          ready_o, mem_we_o, done_o, frame_err_o, ovf_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [AW:0]   word_count_o;
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [AW:0]   wc;
    logic          ovf;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, wr_cnt = 0, base;
  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .rx_i(rx_i), .ready_o(ready_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .done_o(done_o), .frame_err_o(frame_err_o), .ovf_o(ovf_o), .word_count_o(word_count_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && mem_we_o) begin : mon
      exp_t e;
      wr_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr_o, mem_wdata_o);
      end else begin
        e = q.pop_front();
        chk("wr_addr", 32'(mem_addr_o), 32'(e.addr));
        chk("wr_data", mem_wdata_o, e.data);
        chk("wr_count", 32'(word_count_o), 32'(e.wc));
        chk("wr_ovf", 32'(ovf_o), 32'(e.ovf));
        chk("wr_done", 32'(done_o), 32'(e.ovf));
      end
    end
  task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [AW:0] wc, input logic ovf);
    exp_t e;
    e.addr = a; e.data = d; e.wc = wc; e.ovf = ovf;
    q.push_back(e);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = stop;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
    repeat (stop ? 8 : 3 * CPB) @(negedge clk);
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask
  task automatic recycle();
    @(negedge clk) enable_i = 1'b0;
    repeat (4) @(negedge clk);
    enable_i = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic drain(input string name);
    repeat (10) @(negedge clk);
    chk(name, 32'(q.size()), 32'd0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {ready_o, mem_we_o, done_o, frame_err_o, ovf_o, word_count_o, mem_addr_o}, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    enable_i = 1'b1;
    chk("ready_pre", 32'(ready_o), 32'd0);
    @(posedge clk) #1;
    chk("ready_rise", 32'(ready_o), 32'd1);
    expect_wr(2'd0, 32'h1234_5678, 3'd1, 1'b0);
    send_word(32'h1234_5678);
    drain("drain_basic");
    chk("wc_basic", 32'(word_count_o), 32'd1);
    recycle();
    expect_wr(2'd0, 32'h0000_0013, 3'd1, 1'b0);
    expect_wr(2'd1, 32'hDEAD_BEEF, 3'd2, 1'b0);
    expect_wr(2'd2, 32'h0010_0093, 3'd3, 1'b0);
    send_word(32'h0000_0013);
    send_word(32'hDEAD_BEEF);
    send_word(32'h0010_0093);
    send_word(32'h0000_0FFF);
    chk("marker_done", 32'(done_o), 32'd1);
    chk("marker_ready", 32'(ready_o), 32'd0);
    chk("marker_wc", 32'(word_count_o), 32'd3);
    chk("marker_ovf", 32'(ovf_o), 32'd0);
    base = wr_cnt;
    send_word(32'h5555_5555);
    chk("no_write_after_done", 32'(wr_cnt - base), 32'd0);
    drain("drain_marker");
    recycle();
    send_byte(8'h5A, 1'b0);
    chk("frame_err_set", 32'(frame_err_o), 32'd1);
    expect_wr(2'd0, 32'hABCD_EF01, 3'd1, 1'b0);
    send_word(32'hABCD_EF01);
    drain("drain_frame");
    recycle();
    chk("frame_err_clr", 32'(frame_err_o), 32'd0);
    base = wr_cnt;
    @(negedge clk) rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_flags", {done_o, frame_err_o, ovf_o}, 32'd0);
    chk("glitch_writes", 32'(wr_cnt - base), 32'd0);
    expect_wr(2'd0, 32'h0A0B_0C0D, 3'd1, 1'b0);
    send_word(32'h0A0B_0C0D);
    drain("drain_glitch");
    recycle();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    enable_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_ready", 32'(ready_o), 32'd0);
    enable_i = 1'b1;
    repeat (2) @(negedge clk);
    expect_wr(2'd0, 32'h1122_3344, 3'd1, 1'b0);
    send_word(32'h1122_3344);
    drain("drain_abort");
    recycle();
    base = wr_cnt;
    for (int k = 0; k < 4; k++) expect_wr(AW'(k), 32'hC0DE_0000 + 32'(k), 3'(k + 1), k == 3);
    for (int k = 0; k < 5; k++) send_word(32'hC0DE_0000 + 32'(k));
    chk("ovf_flags", {ready_o, done_o, ovf_o}, 32'b011);
    chk("ovf_wc", 32'(word_count_o), 32'd4);
    chk("ovf_writes", 32'(wr_cnt - base), 32'd4);
    drain("drain_ovf");
    recycle();
    chk("pre_rst_ready", 32'(ready_o), 32'd1);
    @(negedge clk) rx_i = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_ctrl", {ready_o, mem_we_o, done_o, frame_err_o, ovf_o, word_count_o, mem_addr_o}, 32'd0);
    chk("async_rst_wdata", mem_wdata_o, 32'd0);
    rx_i = 1'b1;
    enable_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

On-chip counterpart of the UART program-download stream that feeds the BrqRV EB1 SoC:
- Receives 8N1 UART bytes on a single RX line and packs each group of four into a 32-bit word, first byte as MSB.
- Writes each word to consecutive instruction-memory word addresses.
- Stops on the end-of-program marker word 0x00000FFF. The marker is not written.
- Drives `ready_o` to tell the host it may start transmitting, and reports completion, framing errors and overflow.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clk cycles per UART bit. Must be at least 4.
- ADDR_WIDTH, default 12: instruction-memory word-address width, giving 2^ADDR_WIDTH words.

Ports:
- clk  in  1  system clock, the only clock domain.
- rst  in  1  asynchronous, active-high reset.
- enable_i  in  1  level. High requests a program download.
- rx_i  in  1  UART serial input, asynchronous to clk, idle high.
- ready_o  out  1  high while the loader is accepting bytes.
- mem_we_o  out  1  one-cycle write strobe.
- mem_addr_o  out  ADDR_WIDTH  word address for the current write.
- mem_wdata_o  out  32  word to write.
- done_o  out  1  sticky. Marker received or memory full.
- frame_err_o  out  1  sticky. A byte was seen with its stop bit low.
- ovf_o  out  1  sticky. Memory filled before the marker arrived.
- word_count_o  out  ADDR_WIDTH+1  number of words written.

## Operation
- `rx_i` passes through a 2-flop synchronizer, preset to 1 on reset. Every reference to rx below means the synchronized signal.
- The bit receiver has four states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE goes to R_START on rx = 0.
  - R_START waits CLKS_PER_BIT/2 cycles, then samples rx. If rx = 1, the start was false: return to R_IDLE with no side effects. If rx = 0, go to R_DATA.
  - R_DATA samples 8 bits, LSB first, each sample CLKS_PER_BIT cycles after the previous one.
  - R_STOP samples CLKS_PER_BIT cycles after the last data bit. If rx = 1, pulse internal byte_valid for one cycle. If rx = 0, set `frame_err_o` and discard the byte. Either way return to R_IDLE.
- The loader has three states: L_IDLE, L_LOAD, L_DONE.
  - L_IDLE goes to L_LOAD when `enable_i` = 1. On entry, clear the word counter, the byte index and all three sticky flags.
  - In L_LOAD, each byte_valid shifts the byte in: word = {word[23:0], byte}, and byte_idx increments mod 4.
  - When byte_idx wraps after the 4th byte, check the assembled word:
    - If it is 0x00000FFF: set `done_o`, go to L_DONE, no write.
    - Otherwise: issue a write at address word_count[ADDR_WIDTH-1:0], then increment word_count.
    - If the incremented word_count equals 2^ADDR_WIDTH: also set `done_o` and `ovf_o`, and go to L_DONE.
  - L_DONE ignores all further bytes. It returns to L_IDLE when `enable_i` = 0.
  - `enable_i` falling during L_LOAD aborts the download: go to L_IDLE and discard any partial word. Memory already written stays written.
- Bytes that complete while not in L_LOAD are dropped.
- `ready_o` = (state == L_LOAD).

## Timing
- Reset values: every output is 0. Receiver in R_IDLE, loader in L_IDLE, word and byte_idx are 0.
- From an `rx_i` edge to the synchronized rx: 2 cycles.
- `ready_o` rises 1 cycle after `enable_i` is sampled high in L_IDLE.
- byte_valid is asserted in the cycle after the stop-bit sample.
- For the 4th byte, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are registered and valid together in the cycle after byte_valid. `mem_we_o` is high for exactly 1 cycle. Address and data hold until the next write.
- `word_count_o` updates in the same cycle as `mem_we_o`.
- On the marker, `done_o` rises in the cycle after byte_valid and `ready_o` falls in that same cycle.
- On overflow, `done_o` and `ovf_o` rise together with the final `mem_we_o`.
- If byte_valid and an `enable_i` fall occur in the same cycle, the abort wins: the byte is dropped.
- The receiver keeps running regardless of loader state, so a byte in flight at `enable_i` rise is accepted if it completes in L_LOAD.

## Test plan
- Enable, then send bytes 12 34 56 78 → one `mem_we_o` pulse with addr 0, data 0x12345678; `word_count_o` = 1.
- Send words 0x00000013, 0xDEADBEEF, 0x00100093, then bytes 00 00 0F FF → 3 writes at addr 0..2; `done_o` = 1; `ready_o` = 0; `word_count_o` = 3; a following byte causes no write.
- Send a byte with its stop bit held low, then a clean 0xAB → `frame_err_o` = 1; byte_idx advances only for 0xAB.
- Low glitch on `rx_i` shorter than CLKS_PER_BIT/2 - 2 cycles → no byte, no flags, receiver back in R_IDLE.
- Send 2 bytes, drop `enable_i`, re-enable, send 11 22 33 44 → single write at addr 0 with data 0x11223344.
- With ADDR_WIDTH = 2, send 5 non-marker words → 4 writes at addr 0..3; `ovf_o` = 1; `done_o` = 1; 5th word not written. Assert `rst` mid-byte → all outputs 0 immediately.
